// File: rtl/done_sample_sequencer_if.sv
// Handshake bundle between the sample sequencer and the datapath under test:
// outbound sample stream (pix_*) and the returning result stream (res_*).
interface done_sample_sequencer_if #(
    parameter int IDX_W = 10
);
    logic             pix_valid;
    logic             pix_ready;
    logic [15:0]      pix_data;
    logic [IDX_W-1:0] pix_index;
    logic             pix_last;
    logic             res_valid;
    logic [15:0]      res_data;
    logic             res_ready;

    modport master (
        output pix_valid, pix_data, pix_index, pix_last, res_ready,
        input  pix_ready, res_valid, res_data
    );

    modport slave (
        input  pix_valid, pix_data, pix_index, pix_last, res_ready,
        output pix_ready, res_valid, res_data
    );
endinterface

// File: rtl/done_sample_sequencer.sv
// Streams a ROM frame of sample words into the datapath and scores the returned
// results against the expected snapshot within a tolerance, with stall abort.
module done_sample_sequencer #(
    parameter int PIXEL_COUNT    = 784,
    parameter int IDX_W          = 10,
    parameter int TOL            = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [16*PIXEL_COUNT-1:0] sample_flat_i,
    input  logic [16*PIXEL_COUNT-1:0] expected_flat_i,
    input  logic                      has_expected_i,
    input  logic                      data_valid_i,
    done_sample_sequencer_if.master   bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [IDX_W:0]            mismatch_count_o,
    output logic [IDX_W-1:0]          first_mismatch_idx_o
);

    localparam int CNT_W = IDX_W + 1;
    localparam int ST_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] PIX_TOTAL   = CNT_W'(PIXEL_COUNT);
    localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(PIXEL_COUNT - 1);
    localparam logic [ST_W-1:0]  STALL_LIMIT = ST_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      TOL_MAG     = 17'(TOL);
    localparam logic [IDX_W-1:0] NO_MISMATCH = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] send_cnt_q, send_cnt_d;
    logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
    logic [ST_W-1:0]  stall_q, stall_d;
    logic             pix_valid_q, pix_valid_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic [IDX_W-1:0] pix_index_q, pix_index_d;
    logic             pix_last_q, pix_last_d;
    logic             res_ready_q, res_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic [IDX_W-1:0] first_mm_q, first_mm_d;

    logic             pix_hs;
    logic             res_hs;
    logic [IDX_W-1:0] recv_idx;
    logic [15:0]      exp_word;
    logic [16:0]      diff;
    logic [16:0]      diff_mag;

    logic [15:0] sample_w   [PIXEL_COUNT];
    logic [15:0] expected_w [PIXEL_COUNT];

    for (genvar g = 0; g < PIXEL_COUNT; g++) begin : g_unpack
        assign sample_w[g]   = sample_flat_i[16*g +: 16];
        assign expected_w[g] = expected_flat_i[16*g +: 16];
    end

    // Sign-extend both words to 17 bits so the difference never wraps.
    always_comb begin
        pix_hs   = pix_valid_q & bus.pix_ready;
        res_hs   = res_ready_q & bus.res_valid;
        recv_idx = recv_cnt_q[IDX_W-1:0];
        exp_word = expected_w[recv_idx];
        diff     = {bus.res_data[15], bus.res_data} - {exp_word[15], exp_word};
        diff_mag = diff[16] ? (~diff + 17'd1) : diff;
    end

    always_comb begin
        state_d     = state_q;
        send_cnt_d  = send_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        stall_d     = stall_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_index_d = pix_index_q;
        pix_last_d  = pix_last_q;
        res_ready_d = res_ready_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        mm_cnt_d    = mm_cnt_q;
        first_mm_d  = first_mm_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = WAIT_DATA;
                    send_cnt_d  = '0;
                    recv_cnt_d  = '0;
                    stall_d     = '0;
                    pix_index_d = '0;
                    pix_last_d  = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    mm_cnt_d    = '0;
                    first_mm_d  = NO_MISMATCH;
                end
            end

            WAIT_DATA: begin
                if (data_valid_i) begin
                    state_d     = RUN;
                    pix_valid_d = 1'b1;
                    pix_data_d  = sample_w[0];
                    pix_index_d = '0;
                    pix_last_d  = (PIXEL_COUNT == 1);
                    res_ready_d = 1'b1;
                end
            end

            RUN: begin
                // The next word is fetched only on acceptance, so a stalled word holds.
                if (pix_hs) begin
                    send_cnt_d = send_cnt_q + CNT_W'(1);
                    if (send_cnt_d < PIX_TOTAL) begin
                        pix_data_d  = sample_w[send_cnt_d[IDX_W-1:0]];
                        pix_index_d = send_cnt_d[IDX_W-1:0];
                        pix_last_d  = (send_cnt_d == PIX_LAST);
                    end else begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                    end
                end

                if (res_hs) begin
                    if (has_expected_i && (diff_mag > TOL_MAG)) begin
                        mm_cnt_d = mm_cnt_q + CNT_W'(1);
                        if (first_mm_q == NO_MISMATCH) begin
                            first_mm_d = recv_idx;
                        end
                    end
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_d == PIX_TOTAL) begin
                        res_ready_d = 1'b0;
                    end
                end

                stall_d = (pix_hs || res_hs) ? '0 : stall_q + ST_W'(1);

                if ((send_cnt_d == PIX_TOTAL) && (recv_cnt_d == PIX_TOTAL)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    pass_d      = (mm_cnt_d == '0);
                    pix_valid_d = 1'b0;
                    res_ready_d = 1'b0;
                end else if (!pix_hs && !res_hs && (stall_q == STALL_LIMIT)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    res_ready_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WAIT_DATA) || (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            send_cnt_q  <= '0;
            recv_cnt_q  <= '0;
            stall_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_index_q <= '0;
            pix_last_q  <= 1'b0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mm_cnt_q    <= '0;
            first_mm_q  <= NO_MISMATCH;
        end else begin
            state_q     <= state_d;
            send_cnt_q  <= send_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            stall_q     <= stall_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_index_q <= pix_index_d;
            pix_last_q  <= pix_last_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            mm_cnt_q    <= mm_cnt_d;
            first_mm_q  <= first_mm_d;
        end
    end

    assign bus.pix_valid        = pix_valid_q;
    assign bus.pix_data         = pix_data_q;
    assign bus.pix_index        = pix_index_q;
    assign bus.pix_last         = pix_last_q;
    assign bus.res_ready        = res_ready_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign pass_o               = pass_q;
    assign timeout_o            = timeout_q;
    assign mismatch_count_o     = mm_cnt_q;
    assign first_mismatch_idx_o = first_mm_q;

endmodule

// File: tb/tb_done_sample_sequencer.sv
// Directed bench: two sequencers (TOL 0 and TOL 2) share one loopback datapath model
// driven from the TOL 0 instance's outbound stream.
module tb_done_sample_sequencer;

    localparam int PC    = 784;
    localparam int IDX_W = 10;
    localparam int TMO   = 64;
    localparam int BIG   = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [16*PC-1:0]  sampleFlat;
    logic [16*PC-1:0]  expectedFlat;
    logic              hasExpected = 1'b1;
    logic              dataValid = 1'b0;
    logic              pixReady = 1'b0;
    logic              resValid = 1'b0;
    logic [15:0]       resData = 16'h0;

    logic              busyA, doneA, passA, toA;
    logic [IDX_W:0]    mmA;
    logic [IDX_W-1:0]  firstA;
    logic              busyB, doneB, passB, toB;
    logic [IDX_W:0]    mmB;
    logic [IDX_W-1:0]  firstB;

    bit  corrupt   = 1'b0;
    bit  stallMode = 1'b0;
    int  resLimit  = BIG;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } item_t;

    item_t       resQ[$];
    int          sendCount, resSent, seqErrs, holdErrs;
    int          firstSendCyc, lastSendCyc, lastResCyc, lastHsEdge;
    bit          prevStall;
    logic [15:0] prevData;
    logic [IDX_W-1:0] prevIdx;

    done_sample_sequencer_if #(.IDX_W(IDX_W)) busA ();
    done_sample_sequencer_if #(.IDX_W(IDX_W)) busB ();

    assign busA.pix_ready = pixReady;
    assign busA.res_valid = resValid;
    assign busA.res_data  = resData;
    assign busB.pix_ready = pixReady;
    assign busB.res_valid = resValid;
    assign busB.res_data  = resData;

    done_sample_sequencer #(
        .PIXEL_COUNT(PC), .IDX_W(IDX_W), .TOL(0), .TIMEOUT_CYCLES(TMO)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .sample_flat_i(sampleFlat), .expected_flat_i(expectedFlat),
        .has_expected_i(hasExpected), .data_valid_i(dataValid),
        .bus(busA),
        .busy_o(busyA), .done_o(doneA), .pass_o(passA), .timeout_o(toA),
        .mismatch_count_o(mmA), .first_mismatch_idx_o(firstA)
    );

    done_sample_sequencer #(
        .PIXEL_COUNT(PC), .IDX_W(IDX_W), .TOL(2), .TIMEOUT_CYCLES(TMO)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .sample_flat_i(sampleFlat), .expected_flat_i(expectedFlat),
        .has_expected_i(hasExpected), .data_valid_i(dataValid),
        .bus(busB),
        .busy_o(busyB), .done_o(doneB), .pass_o(passB), .timeout_o(toB),
        .mismatch_count_o(mmB), .first_mismatch_idx_o(firstB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback datapath: runs just after each falling edge, so every handshake it
    // records here completes on the following rising edge.
    always begin
        @(negedge clk);
        #1;
        if (start || !rst_n) begin
            resQ.delete();
            sendCount = 0;
            resSent   = 0;
            seqErrs   = 0;
            holdErrs  = 0;
            prevStall = 1'b0;
            pixReady  = 1'b0;
            resValid  = 1'b0;
        end else begin
            pixReady = stallMode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (resQ.size() > 0 && resSent < resLimit &&
                (!stallMode || $urandom_range(0, 1) == 1)) begin
                resValid = 1'b1;
                resData  = resQ[0].data +
                           ((corrupt && (resQ[0].idx == 5 || resQ[0].idx == 300)) ? 16'd2 : 16'd0);
            end else begin
                resValid = 1'b0;
            end

            if (prevStall && (!busA.pix_valid || busA.pix_data !== prevData ||
                              busA.pix_index !== prevIdx))
                holdErrs++;
            prevStall = busA.pix_valid && !pixReady;
            prevData  = busA.pix_data;
            prevIdx   = busA.pix_index;

            if (busA.pix_valid && pixReady) begin
                if (int'(busA.pix_index) != sendCount ||
                    busA.pix_data !== sampleFlat[16*sendCount +: 16] ||
                    busA.pix_last !== (sendCount == PC - 1))
                    seqErrs++;
                if (sendCount == 0) firstSendCyc = cyc;
                lastSendCyc = cyc;
                lastHsEdge  = cyc + 1;
                resQ.push_back('{idx: sendCount, data: busA.pix_data});
                sendCount++;
            end

            if (resValid && busA.res_ready) begin
                void'(resQ.pop_front());
                resSent++;
                lastResCyc = cyc;
                lastHsEdge = cyc + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit corruptIn, input bit stallIn, input int limitIn,
                                 input bit hasExpIn, input int dvDelay);
        int waitErrs;
        @(negedge clk);
        corrupt     = corruptIn;
        stallMode   = stallIn;
        resLimit    = limitIn;
        hasExpected = hasExpIn;
        dataValid   = (dvDelay == 0);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (dvDelay > 0) begin
            waitErrs = 0;
            for (int i = 0; i < dvDelay; i++) begin
                if (!busyA || busA.pix_valid) waitErrs++;
                @(negedge clk);
            end
            checkOutput("busyNoPixWhileWaiting", waitErrs, 0);
            dataValid = 1'b1;
            @(negedge clk);
            checkOutput("pixValidAfterDataValid", busA.pix_valid, 1);
            checkOutput("firstIndexAfterWait", busA.pix_index, 0);
        end
    endtask

    task automatic waitDone(input int budget, output bit ok, output int doneCyc);
        ok = 1'b0;
        doneCyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (doneA) begin
                ok = 1'b1;
                doneCyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int doneCyc;

        for (int i = 0; i < PC; i++) sampleFlat[16*i +: 16] = 16'($urandom);
        sampleFlat[16*5 +: 16]   = 16'hFFFF;
        sampleFlat[16*300 +: 16] = 16'h7FFD;
        expectedFlat = sampleFlat;

        #3 rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDone", doneA, 0);
        checkOutput("rstPass", passA, 0);
        checkOutput("rstTimeout", toA, 0);
        checkOutput("rstMismatch", mmA, 0);
        checkOutput("rstFirstIdx", firstA, 10'h3FF);
        checkOutput("rstPixValid", busA.pix_valid, 0);
        checkOutput("rstPixData", busA.pix_data, 0);
        checkOutput("rstPixIndex", busA.pix_index, 0);
        checkOutput("rstPixLast", busA.pix_last, 0);
        checkOutput("rstResReady", busA.res_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean loopback frame");
        applyStimulus(1'b0, 1'b0, BIG, 1'b1, 0);
        waitDone(3000, ok, doneCyc);
        checkOutput("s1Done", ok, 1);
        checkOutput("s1Sends", sendCount, PC);
        checkOutput("s1Results", resSent, PC);
        checkOutput("s1SendSpan", lastSendCyc - firstSendCyc, PC - 1);
        checkOutput("s1SeqErrs", seqErrs, 0);
        checkOutput("s1DoneLatency", doneCyc - lastResCyc, 1);
        checkOutput("s1Pass", passA, 1);
        checkOutput("s1Mismatch", mmA, 0);
        checkOutput("s1FirstIdx", firstA, 10'h3FF);
        checkOutput("s1Timeout", toA, 0);
        checkOutput("s1Busy", busyA, 0);
        checkOutput("s1PixValid", busA.pix_valid, 0);
        checkOutput("s1ResReady", busA.res_ready, 0);
        checkOutput("s1PassTol2", passB, 1);

        $display("[TB] corrupted words 5 and 300");
        applyStimulus(1'b1, 1'b0, BIG, 1'b1, 0);
        waitDone(3000, ok, doneCyc);
        checkOutput("s2Done", ok, 1);
        checkOutput("s2MismatchTol0", mmA, 2);
        checkOutput("s2FirstTol0", firstA, 5);
        checkOutput("s2PassTol0", passA, 0);
        checkOutput("s2DoneTol2", doneB, 1);
        checkOutput("s2MismatchTol2", mmB, 0);
        checkOutput("s2FirstTol2", firstB, 10'h3FF);
        checkOutput("s2PassTol2", passB, 1);

        $display("[TB] random stalls on both streams");
        applyStimulus(1'b0, 1'b1, BIG, 1'b1, 0);
        waitDone(12000, ok, doneCyc);
        checkOutput("s3Done", ok, 1);
        checkOutput("s3HoldErrs", holdErrs, 0);
        checkOutput("s3SeqErrs", seqErrs, 0);
        checkOutput("s3Sends", sendCount, PC);
        checkOutput("s3Results", resSent, PC);
        checkOutput("s3Pass", passA, 1);
        checkOutput("s3Mismatch", mmA, 0);
        checkOutput("s3FirstIdx", firstA, 10'h3FF);
        checkOutput("s3Timeout", toA, 0);

        $display("[TB] data_valid delayed 20 cycles");
        applyStimulus(1'b0, 1'b0, BIG, 1'b1, 20);
        waitDone(3000, ok, doneCyc);
        checkOutput("s4Done", ok, 1);
        checkOutput("s4SeqErrs", seqErrs, 0);
        checkOutput("s4Pass", passA, 1);

        $display("[TB] results stop after 100 words");
        applyStimulus(1'b0, 1'b0, 100, 1'b1, 0);
        waitDone(3000, ok, doneCyc);
        checkOutput("s5Done", ok, 1);
        checkOutput("s5Timeout", toA, 1);
        checkOutput("s5Pass", passA, 0);
        checkOutput("s5TimeoutLatency", doneCyc - lastHsEdge, TMO);
        checkOutput("s5Results", resSent, 100);
        checkOutput("s5Sends", sendCount, PC);
        checkOutput("s5Mismatch", mmA, 0);

        applyStimulus(1'b0, 1'b0, BIG, 1'b1, 0);
        waitDone(3000, ok, doneCyc);
        checkOutput("s5bDone", ok, 1);
        checkOutput("s5bTimeout", toA, 0);
        checkOutput("s5bPass", passA, 1);
        checkOutput("s5bResults", resSent, PC);

        $display("[TB] reset mid-frame then has_expected=0 frame");
        applyStimulus(1'b1, 1'b0, BIG, 1'b1, 0);
        for (int i = 0; i < 2000 && sendCount < 400; i++) @(negedge clk);
        checkOutput("s6ReachWord400", sendCount >= 400, 1);
        checkOutput("s6MismatchBeforeReset", mmA, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("s6RstPixValid", busA.pix_valid, 0);
        checkOutput("s6RstResReady", busA.res_ready, 0);
        checkOutput("s6RstBusy", busyA, 0);
        checkOutput("s6RstDone", doneA, 0);
        checkOutput("s6RstMismatch", mmA, 0);
        checkOutput("s6RstFirstIdx", firstA, 10'h3FF);
        checkOutput("s6RstPixIndex", busA.pix_index, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, BIG, 1'b0, 0);
        @(negedge clk);
        checkOutput("s6NewPixValid", busA.pix_valid, 1);
        checkOutput("s6NewPixIndex", busA.pix_index, 0);
        waitDone(3000, ok, doneCyc);
        checkOutput("s6Done", ok, 1);
        checkOutput("s6SeqErrs", seqErrs, 0);
        checkOutput("s6Mismatch", mmA, 0);
        checkOutput("s6Pass", passA, 1);
        checkOutput("s6FirstIdx", firstA, 10'h3FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
